multiword_adder_ctrl: RTL and testbench

Sequences a wide multi-precision add or subtract of `N*WORDS` bits through a single `N`-bit carry-lookahead adder, one word per cycle, least-significant word first. Between words it holds the carry in a register. It takes operands through a valid/ready input handshake and returns the result through a valid/ready output handshake. It sits in front of the shared adder datapath, so wide arithmetic does not need a `WORDS`-times-wider adder.

---
 rtl/multiword_adder_pkg.sv | 15 +
 rtl/carry_lookahead_adder.sv | 34 +++
 rtl/multiword_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_multiword_adder_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiword_adder_pkg.sv
// Shared types and sizing helpers for the multi-word add/subtract controller.
package multiword_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-word configuration still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder built as a Kogge-Stone prefix network over generate/propagate.
module carry_lookahead_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] p;
    logic [N-1:0] g_pre;
    logic [N-1:0] p_pre;
    logic [N:0]   c;

    always_comb begin
        p        = a_i ^ b_i;
        g_pre    = a_i & b_i;
        // Fold carry-in into bit 0 so the prefix tree yields carries directly.
        g_pre[0] = g_pre[0] | (p[0] & cin_i);
        p_pre    = p;
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = N - 1; i >= d; i--) begin
                g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-d]);
                p_pre[i] = p_pre[i] & p_pre[i-d];
            end
        end
        c      = {g_pre, cin_i};
        sum_o  = p ^ c[N-1:0];
        cout_o = c[N];
    end

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Sequences an N*WORDS-bit add/subtract through one N-bit adder, LS word first,
// with valid/ready handshakes on operands and result.
module multiword_adder_ctrl
    import multiword_adder_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_sub,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          accept;

    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic [N-1:0]  add_sum;
    logic          add_cout;

    assign accept = in_valid && (state_q == IDLE);
    assign add_a  = a_q[int'(idx_q)*N +: N];
    assign add_b  = b_q[int'(idx_q)*N +: N];

    carry_lookahead_adder #(.N(N)) u_cla (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow_in.
                    carry_d = op_sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*N +: N] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = sub_q ? ~add_cout : add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand registers carry no reset: they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            sub_q <= op_sub;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Scoreboard bench for multiword_adder_ctrl at N=32, WORDS=4.
module tb_multiword_adder_ctrl;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multiword_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic s, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c);
        exp_t   e;
        logic [W:0] r;
        if (!s) begin
            r      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            e.ovf  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
            e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        e.sum  = r[W-1:0];
        e.cout = r[W];
        return e;
    endfunction

    // Drives one operation, pushes its expected result, and returns once out_valid
    // is seen (lat = edges after acceptance) or the cycle budget runs out.
    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; op_sub = s; a = x; b = y; cin = c;
        q.push_back(model(s, x, y, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_state: ready/valid/busy/cout/ovf=%b sum=%h required 10000 sum=0",
                     {in_ready, out_valid, busy, cout, ovf}, sum);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_arith(input string name, input int nvec, input logic [W-1:0] xs[6],
                              input logic [W-1:0] ys[6], input logic cs[6], input logic ss[6]);
        int   lat;
        exp_t e;
        for (int i = 0; i < nvec; i++) begin
            run_op(ss[i], xs[i], ys[i], cs[i], lat);
            e = q.pop_front();
            checks++;
            if (lat !== WORDS || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_latency[%0d]: lat=%0d busy=%b in_ready=%b required %0d 1 0",
                         name, i, lat, busy, in_ready, WORDS);
            end
            checks++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s_result[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                         name, i, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            release_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_handshake[%0d]: out_valid=%b in_ready=%b required 0 1",
                         name, i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_add();
        logic [W-1:0] xs[6], ys[6];
        logic         cs[6], ss[6];
        xs = '{default: '0}; ys = '{default: '0}; cs = '{default: 1'b0}; ss = '{default: 1'b0};
        xs[0] = {W{1'b1}};                                   ys[0] = 1;
        xs[1] = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; ys[1] = 1;
        xs[2] = 0;                                           ys[2] = 0; cs[2] = 1'b1;
        test_arith("add", 3, xs, ys, cs, ss);
    endtask

    task automatic test_sub();
        logic [W-1:0] xs[6], ys[6];
        logic         cs[6], ss[6];
        xs = '{default: '0}; ys = '{default: '0}; cs = '{default: 1'b0}; ss = '{default: 1'b1};
        xs[0] = 0; ys[0] = 1;
        xs[1] = 5; ys[1] = 3;
        xs[2] = 5; ys[2] = 3; cs[2] = 1'b1;
        test_arith("sub", 3, xs, ys, cs, ss);
    endtask

    task automatic test_ovf();
        logic [W-1:0] xs[6], ys[6];
        logic         cs[6], ss[6];
        xs = '{default: '0}; ys = '{default: '0}; cs = '{default: 1'b0}; ss = '{default: 1'b0};
        xs[0] = {1'b0, {(W-1){1'b1}}}; ys[0] = 1;
        xs[1] = {1'b1, {(W-1){1'b0}}}; ys[1] = 1; ss[1] = 1'b1;
        test_arith("ovf", 2, xs, ys, cs, ss);
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        run_op(1'b0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, lat);
        e = q.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_sub   = i[1];
            a        = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b sum=%h cout=%b ovf=%b required 1 0 sum=%h cout=%b ovf=%b",
                         i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        exp_t e;
        in_valid = 1'b1; op_sub = 1'b0; a = {W{1'b1}}; b = {W{1'b1}}; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: ready/valid/busy/cout/ovf=%b sum=%h required 10000 sum=0",
                     {in_ready, out_valid, busy, cout, ovf}, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 3, 10, 1'b0, lat);
        e = q.pop_front();
        checks++;
        if (lat !== WORDS || sum !== e.sum || sum !== 128'd13 || cout !== e.cout || ovf !== e.ovf) begin
            errors++;
            $display("FAIL post_reset_add: lat=%0d sum=%h cout=%b ovf=%b required lat=%0d sum=%h cout=%b ovf=%b",
                     lat, sum, cout, ovf, WORDS, e.sum, e.cout, e.ovf);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        logic s;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            run_op(s, {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), lat);
            e = q.pop_front();
            checks++;
            if (lat !== WORDS || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                errors++;
                $display("FAIL back_to_back[%0d]: lat=%0d sum=%h cout=%b ovf=%b required lat=%0d sum=%h cout=%b ovf=%b",
                         i, lat, sum, cout, ovf, WORDS, e.sum, e.cout, e.ovf);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
